// File: rtl/cla_restoring_divider_pkg.sv
// Shared definitions for the restoring divider and its lookahead subtractor slice.
package cla_restoring_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CLA_GROUP = 4;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cla_restoring_divider_sub.sv
// WIDTH-bit a-b as a + ~b + 1 through chained 4-bit carry-lookahead groups.
module cla_subtractor
  import cla_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] w_bn;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [NG:0]      w_gc;

  assign w_bn = ~i_b;
  assign w_g  = i_a & w_bn;
  assign w_p  = i_a ^ w_bn;

  // The +1 of the two's-complement negation enters as the LSB group carry-in.
  assign w_gc[0] = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] w_gg;
    logic [3:0] w_gp;
    logic       w_ci;

    assign w_gg = w_g[k*CLA_GROUP +: CLA_GROUP];
    assign w_gp = w_p[k*CLA_GROUP +: CLA_GROUP];
    assign w_ci = w_gc[k];

    assign w_c[k*CLA_GROUP+0] = w_ci;
    assign w_c[k*CLA_GROUP+1] = w_gg[0] | (w_gp[0] & w_ci);
    assign w_c[k*CLA_GROUP+2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_ci);
    assign w_c[k*CLA_GROUP+3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                              | (w_gp[2] & w_gp[1] & w_gp[0] & w_ci);
    assign w_gc[k+1] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                     | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                     | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_ci);
  end

  assign o_diff   = w_p ^ w_c;
  assign o_borrow = ~w_gc[NG];

endmodule

// File: rtl/cla_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module cla_restoring_divider
  import cla_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_qsr;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH-1:0] w_trial_lo;
  logic [WIDTH-1:0] w_diff;
  logic             w_sub_borrow;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_q;
  logic             w_accept;

  // The trial value is WIDTH+1 bits: r_rem[WIDTH-1] on top of w_trial_lo.
  assign w_trial_lo = {r_rem[WIDTH-2:0], r_qsr[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH)) u_sub (
    .i_a      (w_trial_lo),
    .i_b      (r_div),
    .o_diff   (w_diff),
    .o_borrow (w_sub_borrow)
  );

  // A set top bit means the trial value is >= 2^WIDTH > divisor, so no borrow;
  // the true difference is then below the divisor and its low bits are exact.
  assign w_borrow   = w_sub_borrow & ~r_rem[WIDTH-1];
  assign w_next_rem = w_borrow ? w_trial_lo : w_diff;
  assign w_next_q   = {r_qsr[WIDTH-2:0], ~w_borrow};
  assign w_accept   = start && (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_div <= divisor;
      r_qsr <= dividend;
      r_rem <= '0;
    end else if (r_state == S_RUN) begin
      r_rem <= w_next_rem;
      r_qsr <= w_next_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remo  <= dividend;
              r_dz    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= CW'(WIDTH - 1);
              r_ready <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_quot  <= w_next_q;
            r_remo  <= w_next_rem;
            r_dz    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_cla_restoring_divider.sv
// Self-checking bench for cla_restoring_divider: directed plan steps plus random operands.
module tb_cla_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_z = 1'b0;

  always #5 clk = ~clk;

  cla_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Called 1 time unit after a rising edge with the DUT ready; returns just after done rises.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit glitch);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           e;
    int           exp_e;
    ref_div(a, b, eq, er, ez);
    exp_e    = (b == '0) ? 0 : W;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    e = 0;
    while (!done && e < 4 * W) begin
      chk({tag, "_ready_low"}, 32'(ready), 32'(0));
      chk({tag, "_held_q"}, 32'(quotient), 32'(held_q));
      chk({tag, "_held_r"}, 32'(remainder), 32'(held_r));
      if (glitch && e == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(e), 32'(exp_e));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(ez));
    chk({tag, "_ready_done"}, 32'(ready), 32'(1));
    held_q = eq;
    held_r = er;
    held_z = ez;
  endtask

  task automatic done_drop(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_ready_idle"}, 32'(ready), 32'(1));
    chk({tag, "_hold_q"}, 32'(quotient), 32'(held_q));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_div_zero", 32'(div_zero), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'd200, 8'd7, "t1", 1'b0);
    chk("t1_q_28", 32'(quotient), 32'(28));
    chk("t1_r_4", 32'(remainder), 32'(4));
    done_drop("t1");

    run_op(8'd255, 8'd1, "t2a", 1'b0);
    done_drop("t2a");
    run_op(8'd5, 8'd9, "t2b", 1'b0);
    done_drop("t2b");
    run_op(8'd13, 8'd13, "t2c", 1'b0);
    chk("t2c_q_1", 32'(quotient), 32'(1));
    done_drop("t2c");

    run_op(8'd77, 8'd0, "t3a", 1'b0);
    chk("t3a_r_77", 32'(remainder), 32'(77));
    done_drop("t3a");
    run_op(8'd10, 8'd3, "t3b", 1'b0);
    done_drop("t3b");

    run_op(8'd100, 8'd3, "t4", 1'b1);
    chk("t4_q_33", 32'(quotient), 32'(33));

    run_op(8'd100, 8'd10, "t5", 1'b0);
    done_drop("t5");

    // Abort 200/7 with an asynchronous reset between clock edges.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_abort_quotient", 32'(quotient), 32'(0));
    chk("t6_abort_remainder", 32'(remainder), 32'(0));
    chk("t6_abort_div_zero", 32'(div_zero), 32'(0));
    chk("t6_abort_ready", 32'(ready), 32'(1));
    chk("t6_abort_done", 32'(done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    held_q = '0;
    held_r = '0;
    held_z = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("t6_no_done", 32'(done), 32'(0));
    end
    run_op(8'd9, 8'd2, "t6", 1'b0);
    done_drop("t6");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 7));
      else rb = W'($urandom_range(0, 255));
      run_op(ra, rb, "rnd", 1'b0);
      if ($urandom_range(0, 1) == 1) done_drop("rnd");
    end
    done_drop("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
